// File: rtl/cam_axi_lite_regs_if.sv
// AXI4-Lite bus bundle for the camera control register file.
// Signal names drop the s00_axi_ prefix; the instance name supplies it.
interface cam_axi_lite_regs_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cam_axi_lite_regs.sv
// AXI4-Lite register file for the camera IP: NUM_REGS x 32-bit control registers.
// Define CAM_AXI_LITE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module cam_axi_lite_regs #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_areset,
  cam_axi_lite_regs_if.slave             s00_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = ADDR_WIDTH - 2;

  localparam logic [1:0] RespOkay = 2'b00;
`ifdef CAM_AXI_LITE_SLVERR_EN
  localparam logic [1:0] RespOor  = 2'b10;
`else
  localparam logic [1:0] RespOor  = 2'b00;
`endif

  typedef enum logic [0:0] {WIdle, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] aw_addr_eff;
  logic [DATA_WIDTH-1:0] wdata_eff;
  logic [StrbW-1:0]      wstrb_eff;
  logic [IdxW-1:0]       w_idx, r_idx;
  logic                  w_in_range, r_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  assign aw_hs = s00_axi.awvalid && awready_q;
  assign w_hs  = s00_axi.wvalid && wready_q;
  assign ar_hs = s00_axi.arvalid && arready_q;

  // A beat arriving this cycle takes precedence over an empty holding register.
  assign aw_addr_eff = aw_hs ? s00_axi.awaddr : awaddr_q;
  assign wdata_eff   = w_hs ? s00_axi.wdata : wdata_q;
  assign wstrb_eff   = w_hs ? s00_axi.wstrb : wstrb_q;

  assign w_idx      = aw_addr_eff[ADDR_WIDTH-1:2];
  assign w_in_range = 32'(w_idx) < NUM_REGS;
  assign r_idx      = s00_axi.araddr[ADDR_WIDTH-1:2];
  assign r_in_range = 32'(r_idx) < NUM_REGS;

  always_comb begin
    w_state_d = w_state_q;
    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    case (w_state_q)
      WIdle: begin
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          if (w_in_range) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (32'(w_idx) == i) begin
                for (int unsigned k = 0; k < StrbW; k++) begin
                  if (wstrb_eff[k]) regs_d[i][k*8 +: 8] = wdata_eff[k*8 +: 8];
                end
              end
            end
          end
          w_state_d = WResp;
          bvalid_d  = 1'b1;
          bresp_d   = w_in_range ? RespOkay : RespOor;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s00_axi.awaddr;
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s00_axi.wdata;
            wstrb_d  = s00_axi.wstrb;
          end
          // Also raises the readies on the first cycle out of reset.
          awready_d = !(aw_held_q || aw_hs);
          wready_d  = !(w_held_q || w_hs);
        end
      end
      WResp: begin
        if (s00_axi.bready) begin
          w_state_d = WIdle;
          bvalid_d  = 1'b0;
          bresp_d   = RespOkay;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(r_idx) == i) rd_word = regs_q[i];
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      RIdle: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          // regs_q, not regs_d: a same-cycle write is not visible to this read.
          r_state_d = RData;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = r_in_range ? rd_word : '0;
          rresp_d   = r_in_range ? RespOkay : RespOor;
        end
      end
      RData: begin
        if (s00_axi.rready) begin
          r_state_d = RIdle;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state_q <= WIdle;
      regs_q    <= '0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = rresp_q;

  assign reg_out = regs_q;

  logic unused_in;
  assign unused_in = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

endmodule

// File: tb/tb_cam_axi_lite_regs.sv
// Directed self-checking bench for cam_axi_lite_regs (honours CAM_AXI_LITE_SLVERR_EN).
module tb_cam_axi_lite_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] reg_out;
  int           n_cmp = 0;
  int           n_bad = 0;

`ifdef CAM_AXI_LITE_SLVERR_EN
  localparam logic [1:0] OorResp = 2'b10;
`else
  localparam logic [1:0] OorResp = 2'b00;
`endif

  always #5 clk = ~clk;

  cam_axi_lite_regs_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi ();

  cam_axi_lite_regs #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS  (4)
  ) dut (
    .s00_axi_aclk  (clk),
    .s00_axi_areset(rst),
    .s00_axi       (axi),
    .reg_out       (reg_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input string tag);
    int   cnt = 0;
    logic aw_p = 1'b1;
    logic w_p  = 1'b1;
    logic aw_f, w_f;
    axi.awaddr  = addr;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    while ((aw_p || w_p) && cnt < 20) begin
      aw_f = aw_p && axi.awready;
      w_f  = w_p && axi.wready;
      tick();
      if (aw_f) begin axi.awvalid = 1'b0; aw_p = 1'b0; end
      if (w_f) begin axi.wvalid = 1'b0; w_p = 1'b0; end
      cnt++;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    check({tag, "_hs"}, {aw_p, w_p}, 2'b00);
    check({tag, "_bvalid"}, axi.bvalid, 1'b1);
    check({tag, "_bresp"}, axi.bresp, exp_resp);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    int cnt = 0;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    while (!axi.arready && cnt < 20) begin
      tick();
      cnt++;
    end
    tick();
    axi.arvalid = 1'b0;
    check({tag, "_rvalid"}, axi.rvalid, 1'b1);
    check({tag, "_rdata"}, axi.rdata, exp_data);
    check({tag, "_rresp"}, axi.rresp, exp_resp);
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awaddr  = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata   = '0; axi.wstrb  = '0; axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.araddr  = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    check("rst_awready", axi.awready, 1'b0);
    check("rst_wready", axi.wready, 1'b0);
    check("rst_bvalid", axi.bvalid, 1'b0);
    check("rst_arready", axi.arready, 1'b0);
    check("rst_rvalid", axi.rvalid, 1'b0);
    check("rst_resp", {axi.bresp, axi.rresp}, 4'b0000);
    check("rst_rdata", axi.rdata, 32'h0);
    check("rst_reg_out", reg_out, 128'h0);

    rst = 1'b0;
    tick();
    check("post_rst_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);

    // Sequential write / readback
    for (int i = 0; i < 4; i++) axi_write(5'(i * 4), 32'(i + 1), 4'hF, 2'b00, "wr_seq");
    for (int i = 0; i < 4; i++) axi_read(5'(i * 4), 32'(i + 1), 2'b00, "rd_seq");
    check("seq_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

    // Byte strobes and unaligned read
    axi_write(5'h04, 32'hAABBCCDD, 4'b1111, 2'b00, "wr_strb_full");
    axi_write(5'h04, 32'h11223344, 4'b0101, 2'b00, "wr_strb_part");
    axi_read(5'h04, 32'hAA22CC44, 2'b00, "rd_strb");
    axi_read(5'h06, 32'hAA22CC44, 2'b00, "rd_unaligned");

    // W leads AW by three cycles
    axi.awaddr = 5'h08; axi.wdata = 32'h5555_0008; axi.wstrb = 4'hF;
    axi.wvalid = 1'b1;
    check("wfirst_wready", axi.wready, 1'b1);
    tick();
    axi.wvalid = 1'b0;
    tick();
    tick();
    check("wfirst_wait", {axi.wready, axi.awready, axi.bvalid}, 3'b010);
    check("wfirst_nocommit", reg_out[95:64], 32'h3);
    axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    check("wfirst_bvalid_lat", axi.bvalid, 1'b1);
    check("wfirst_reg", reg_out[95:64], 32'h5555_0008);
    axi.bready = 1'b1; tick(); axi.bready = 1'b0;

    // AW leads W by three cycles
    axi.awaddr = 5'h0C; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    tick();
    tick();
    check("awfirst_wait", {axi.awready, axi.wready, axi.bvalid}, 3'b010);
    axi.wdata = 32'h6666_000C; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    check("awfirst_bvalid_lat", axi.bvalid, 1'b1);
    check("awfirst_reg", reg_out[127:96], 32'h6666_000C);
    axi.bready = 1'b1; tick(); axi.bready = 1'b0;
    axi_read(5'h08, 32'h5555_0008, 2'b00, "rd_wfirst");

    // Commit and AR to the same register in one cycle: read sees the old value
    axi.awaddr = 5'h08; axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.araddr = 5'h08; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    check("same_cyc_valids", {axi.bvalid, axi.rvalid}, 2'b11);
    check("same_cyc_rdata", axi.rdata, 32'h5555_0008);
    check("same_cyc_reg", reg_out[95:64], 32'h1234_5678);
    axi.bready = 1'b1; axi.rready = 1'b1; tick(); axi.bready = 1'b0; axi.rready = 1'b0;

    // Backpressure on both response channels with a second request pending
    axi.awaddr = 5'h00; axi.wdata = 32'h77; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.araddr = 5'h04; axi.arvalid = 1'b1;
    tick();
    axi.wdata = 32'h99; axi.araddr = 5'h00;
    for (int i = 0; i < 10; i++) begin
      check("bp_stable",
            {axi.bvalid, axi.bresp, axi.awready, axi.wready, axi.arready, axi.rvalid, axi.rdata},
            {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA22CC44});
      tick();
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    axi.bready = 1'b1; axi.rready = 1'b1;
    tick();
    axi.bready = 1'b0; axi.rready = 1'b0;
    check("bp_released", {axi.bvalid, axi.rvalid}, 2'b00);
    check("bp_single_commit", reg_out[31:0], 32'h77);

    // Out-of-range accesses
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, OorResp, "wr_oor");
    axi_read(5'h10, 32'h0, OorResp, "rd_oor");
    axi_read(5'h1C, 32'h0, OorResp, "rd_oor_top");
    check("oor_regs_kept", reg_out,
          {32'h6666_000C, 32'h1234_5678, 32'hAA22CC44, 32'h0000_0077});

    // Reset while a write response is pending
    axi.awaddr = 5'h04; axi.wdata = 32'hCAFE; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check("mid_bvalid", axi.bvalid, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_outputs", {axi.bvalid, axi.awready, axi.wready}, 3'b000);
    check("mid_rst_reg_out", reg_out, 128'h0);
    rst = 1'b0;
    tick();
    check("mid_rst_ready", {axi.awready, axi.wready}, 2'b11);
    axi_write(5'h0C, 32'hBEEF_0003, 4'hF, 2'b00, "wr_after_rst");
    axi_read(5'h0C, 32'hBEEF_0003, 2'b00, "rd_after_rst");
    check("after_rst_reg_out", reg_out, {32'hBEEF_0003, 96'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_axi_lite_regs.md
Name: cam_axi_lite_regs

Overview:
- AXI4-Lite slave (responder) register file for the camera AXI IP.
- Serves host-side AXI4-Lite write/read bursts (single beat) into NUM_REGS 32-bit control registers.
- Exposes all registers as a flat bus to camera datapath logic.
- Independent write and read channel FSMs; one outstanding transaction per direction.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 supported.
- ADDR_WIDTH, 5, byte-address width; register index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4, implemented registers; indices >= NUM_REGS are out of range.

Ports:
- s00_axi_aclk  in  1  clock.
- s00_axi_areset  in  1  synchronous active-high reset.
- s00_axi_awaddr  in  ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake.
- s00_axi_wdata  in  DATA_WIDTH  write data.
- s00_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake.
- s00_axi_araddr  in  ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake.
- s00_axi_rdata  out  DATA_WIDTH  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake.
- reg_out  out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*32 +: 32].

Behaviour:
- Reset, synchronous and active-high: all registers = 0; awready, wready, bvalid, arready, rvalid = 0; bresp, rresp = 2'b00; rdata = 0. Reset mid-transaction drops it; no response is issued.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in either order or in the same cycle; each is latched on its handshake.
  - Commit occurs in the cycle both are held. Byte k of the selected register is updated iff wstrb[k]. FSM moves to W_RESP with bvalid=1 the next cycle.
  - Minimum latency: AW+W handshake in cycle N gives bvalid in cycle N+1.
  - W_RESP: awready=wready=0. bvalid and bresp are held until bready. On B handshake, return to W_IDLE; awready and wready reassert the following cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake in cycle N, rdata/rresp are registered; rvalid=1 in cycle N+1 and the FSM enters R_DATA.
  - R_DATA: arready=0. rdata, rresp and rvalid are stable until rready; return to R_IDLE on R handshake.
- Address decode: the low 2 address bits are ignored (unaligned access hits the containing word).
- Simultaneous write commit and AR handshake to the same register in cycle N: read returns the pre-write value.
- Read and write FSMs operate fully concurrently; neither blocks the other.
- reg_out reflects a commit one cycle after the commit cycle (registered).
- Back-to-back writes: maximum throughput is one write per 2 cycles when bready is held high. Reads have the same limit.

Optional Feature:
- Macro: CAM_AXI_LITE_SLVERR_EN.
- Defined: an out-of-range write is dropped with bresp=2'b10 (SLVERR). An out-of-range read returns rdata=0, rresp=2'b10.
- Undefined: out-of-range writes are silently dropped with bresp=2'b00; out-of-range reads return rdata=0, rresp=2'b00.
- Handshake timing is identical in both builds.

Test Plan:
- Sequential write/readback: write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C, then read the same addresses -> rdata 0x1..0x4, all bresp/rresp 00, reg_out = 0x00000004_00000003_00000002_00000001.
- Byte strobes: write 0xAABBCCDD to 0x04 with wstrb=4'b1111, then 0x11223344 with wstrb=4'b0101 -> read 0x04 returns 0xAA22CC44.
- AW/W ordering: W presented 3 cycles before AW, then AW alone -> single commit, bvalid exactly 1 cycle after the AW handshake. Repeat with AW first -> same result.
- Backpressure: hold bready=0 and rready=0 for 10 cycles -> bvalid/rvalid and bresp/rdata stable throughout; awready/arready stay 0; no second transaction is accepted.
- Out of range: write 0xDEADBEEF to 0x10, then read 0x10 -> with CAM_AXI_LITE_SLVERR_EN: bresp=10, rresp=10, rdata=0. Without it: both responses 00, rdata=0. In both builds, regs 0..3 are unchanged.
- Reset mid-operation: assert s00_axi_areset while bvalid=1 and bready=0 -> next cycle bvalid=0, awready=0, reg_out=0. After deassert, awready and wready return to 1 and a new write completes normally.
